// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the shiftable fixed-priority arbiter and dispatcher.
package arbiter_pkg;

   typedef enum logic {EMPTY, HOLD} state_t;

   // Width of an index into n ports, never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Compare-and-wrap increment so non-power-of-two port counts wrap correctly.
   function automatic int next_prio(input int lp, input int n);
      return (lp + 1 >= n) ? 0 : lp + 1;
   endfunction

endpackage

// File: rtl/dispatcher_fixed_shiftable_if.sv
// Producer and consumer handshake bundle for the 1-to-N dispatcher.
interface dispatcher_fixed_shiftable_if #(
   parameter int DWIDTH = 16,
   parameter int N      = 2
);
   logic                         in_valid;
   logic [DWIDTH-1:0]            in_data;
   logic                         in_ready;
   logic                         shift;
   logic [N-1:0]                 out_valid;
   logic [N-1:0][DWIDTH-1:0]     out_data;
   logic [N-1:0]                 out_ready;

   modport master (
      output in_valid, in_data, shift, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, shift, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/rotating_priority_select.sv
// Combinational pick of the first requester scanning upward from (lp+1)%N with wrap.
module rotating_priority_select
   import arbiter_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]              req,
   input  logic [idx_width(N)-1:0]   lp,
   output logic [N-1:0]              grant,
   output logic                      any
);
   typedef logic [idx_width(N)-1:0] idx_t;

   always_comb begin
      int   pos;
      idx_t sel;
      grant = '0;
      any   = 1'b0;
      pos   = 0;
      sel   = '0;
      for (int k = 0; k < N; k++) begin
         pos = int'(lp) + 1 + k;
         if (pos >= N) pos = pos - N;
         sel = idx_t'(pos);
         if (!any && req[sel]) begin
            grant[sel] = 1'b1;
            any        = 1'b1;
         end
      end
   end
endmodule

// File: rtl/dispatcher_fixed_shiftable.sv
// One-entry 1-to-N stream dispatcher with a rotating priority ring.
// Define DISPATCHER_COUNT_EN to add saturating per-port dispatch counters.
module dispatcher_fixed_shiftable
   import arbiter_pkg::*;
#(
   parameter int DWIDTH           = 16,
   parameter int N                = 2,
   parameter int INIT_LOWEST_PRIO = N - 1
`ifdef DISPATCHER_COUNT_EN
   ,parameter int CNT_WIDTH       = 16
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   dispatcher_fixed_shiftable_if.slave  bus
`ifdef DISPATCHER_COUNT_EN
   ,output logic [N-1:0][CNT_WIDTH-1:0] dispatch_count
`endif
);
   typedef logic [idx_width(N)-1:0] idx_t;

   state_t            state_q, state_d;
   idx_t              lp_q, lp_d;
   idx_t              tgt_q, tgt_d;
   logic [DWIDTH-1:0] data_q, data_d;
   logic              full, fire_in, fire_out, in_ready_c;
   logic [N-1:0]      grant;
   logic              any;
   idx_t              grant_idx;

   rotating_priority_select #(.N(N)) u_select (
      .req   (bus.out_ready),
      .lp    (lp_q),
      .grant (grant),
      .any   (any)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) grant_idx = idx_t'(i);
      end
   end

   // Selection always uses the current lp; a same-cycle shift only affects later captures.
   always_comb begin
      state_d    = state_q;
      lp_d       = lp_q;
      tgt_d      = tgt_q;
      data_d     = data_q;
      full       = (state_q == HOLD);
      fire_out   = full & bus.out_ready[tgt_q];
      in_ready_c = !full | fire_out;
      fire_in    = bus.in_valid & in_ready_c;
      if (bus.shift) lp_d = idx_t'(next_prio(int'(lp_q), N));
      if (fire_in) begin
         state_d = HOLD;
         data_d  = bus.in_data;
         tgt_d   = any ? grant_idx : idx_t'(next_prio(int'(lp_q), N));
      end else if (fire_out) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         lp_q    <= idx_t'(INIT_LOWEST_PRIO);
         tgt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         lp_q    <= lp_d;
         tgt_q   <= tgt_d;
         data_q  <= data_d;
      end
   end

   assign bus.in_ready = in_ready_c;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         bus.out_valid[i] = full && (tgt_q == idx_t'(i));
         bus.out_data[i]  = data_q;
      end
   end

`ifdef DISPATCHER_COUNT_EN
   logic [N-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (fire_out && (cnt_q[tgt_q] != {CNT_WIDTH{1'b1}}))
         cnt_d[tgt_q] = cnt_q[tgt_q] + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign dispatch_count = cnt_q;
`endif
endmodule

// File: tb/tb_dispatcher_fixed_shiftable.sv
// Directed self-checking bench for dispatcher_fixed_shiftable with N=4.
module tb_dispatcher_fixed_shiftable;
   logic clk = 1'b0;
   logic rst;
   int   checkCount = 0;
   int   passCount  = 0;
   int   recv;

   dispatcher_fixed_shiftable_if #(.DWIDTH(16), .N(4)) bus ();

`ifdef DISPATCHER_COUNT_EN
   logic [3:0][1:0] dispatch_count;
   dispatcher_fixed_shiftable #(.DWIDTH(16), .N(4), .INIT_LOWEST_PRIO(3), .CNT_WIDTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .dispatch_count (dispatch_count)
   );
`else
   dispatcher_fixed_shiftable #(.DWIDTH(16), .N(4), .INIT_LOWEST_PRIO(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
   endtask

   task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic [3:0] ready, input logic sh);
      bus.in_valid  = valid;
      bus.in_data   = data;
      bus.out_ready = ready;
      bus.shift     = sh;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0, 4'b0000, 1'b0);
      #12;
      checkOutput("reset_valid", bus.out_valid, 4'b0000);
      checkOutput("reset_data", bus.out_data[0], 16'h0);
      checkOutput("reset_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Push A with all consumers ready: lp=3 so port 0 wins.
      applyStimulus(1'b1, 16'hA001, 4'b1111, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 4'b1111, 1'b0);
      @(negedge clk);
      checkOutput("a_valid", bus.out_valid, 4'b0001);
      checkOutput("a_data0", bus.out_data[0], 16'hA001);
      checkOutput("a_data3", bus.out_data[3], 16'hA001);
      tick();
      @(negedge clk);
      checkOutput("a_drained", bus.out_valid, 4'b0000);
      tick();

      // Push B with nobody ready: falls back to (lp+1)%N and holds.
      applyStimulus(1'b1, 16'hB002, 4'b0000, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 4'b0000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("b_hold_valid", bus.out_valid, 4'b0001);
         checkOutput("b_hold_data", bus.out_data[0], 16'hB002);
         checkOutput("b_hold_in_ready", bus.in_ready, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 16'h0, 4'b0001, 1'b0);
      @(negedge clk);
      checkOutput("b_release_in_ready", bus.in_ready, 1'b1);
      checkOutput("b_release_valid", bus.out_valid, 4'b0001);
      tick();
      @(negedge clk);
      checkOutput("b_drained", bus.out_valid, 4'b0000);
      tick();

      // Three shifts take lp 3->0->1->2; shift in the capture cycle still uses lp=2.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h0, 4'b0000, 1'b1);
         tick();
      end
      applyStimulus(1'b1, 16'hC003, 4'b1111, 1'b1);
      tick();
      applyStimulus(1'b0, 16'h0, 4'b0000, 1'b0);
      @(negedge clk);
      checkOutput("c_valid", bus.out_valid, 4'b1000);
      checkOutput("c_data", bus.out_data[3], 16'hC003);
      applyStimulus(1'b0, 16'h0, 4'b1000, 1'b0);
      tick();

      // lp is now 3 so the next capture goes to port 0.
      applyStimulus(1'b1, 16'hD004, 4'b1111, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 4'b1111, 1'b0);
      @(negedge clk);
      checkOutput("d_valid", bus.out_valid, 4'b0001);
      tick();

      // Only port 2 ready: scan skips ports 0 and 1.
      applyStimulus(1'b1, 16'hE005, 4'b0100, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 4'b0100, 1'b0);
      @(negedge clk);
      checkOutput("e_valid", bus.out_valid, 4'b0100);
      checkOutput("e_data", bus.out_data[2], 16'hE005);
      tick();
      @(negedge clk);
      checkOutput("e_drained", bus.out_valid, 4'b0000);
      tick();

      // 100 items back to back at full rate.
      recv = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, 16'(i), 4'b1111, 1'b0);
         @(negedge clk);
         checkOutput("b2b_in_ready", bus.in_ready, 1'b1);
         if (|bus.out_valid) begin
            checkOutput("b2b_valid", bus.out_valid, 4'b0001);
            checkOutput("b2b_data", bus.out_data[0], 64'(recv));
            recv++;
         end
         tick();
      end
      applyStimulus(1'b0, 16'h0, 4'b1111, 1'b0);
      @(negedge clk);
      if (|bus.out_valid) begin
         checkOutput("b2b_data", bus.out_data[0], 64'(recv));
         recv++;
      end
      checkOutput("b2b_count", 64'(recv), 64'd100);
      tick();

      // Reset during HOLD: shift lp to 0 so the held item sits on port 1.
      applyStimulus(1'b0, 16'h0, 4'b0000, 1'b1);
      tick();
      applyStimulus(1'b1, 16'hF006, 4'b0000, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 4'b0000, 1'b0);
      @(negedge clk);
      checkOutput("f_valid", bus.out_valid, 4'b0010);
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_mid_valid", bus.out_valid, 4'b0000);
      checkOutput("rst_mid_data", bus.out_data[1], 16'h0);
      rst = 1'b1;
      tick();
      applyStimulus(1'b1, 16'h1007, 4'b1111, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 4'b1111, 1'b0);
      @(negedge clk);
      checkOutput("post_rst_valid", bus.out_valid, 4'b0001);
      checkOutput("post_rst_data", bus.out_data[0], 16'h1007);
      tick();

`ifdef DISPATCHER_COUNT_EN
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 16'(i), 4'b0010, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 16'h0, 4'b0010, 1'b0);
      tick();
      tick();
      @(negedge clk);
      checkOutput("cnt_port1", dispatch_count[1], 2'd3);
      checkOutput("cnt_port0", dispatch_count[0], 2'd0);
      checkOutput("cnt_port2", dispatch_count[2], 2'd0);
      checkOutput("cnt_port3", dispatch_count[3], 2'd0);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
